// File: rtl/slide_pkg.sv
// Shared types and constants for the 4x4 sliding-puzzle move path.
// Positions are 1-based (1..16), row-major, carried in POS_W bits.
package slide_pkg;

   localparam int POS_W      = 5;
   localparam int NUM_BLOCKS = 16;
   localparam int CNT_W      = 10;

   localparam logic [CNT_W-1:0] CNT_MAX = 10'd999;

   typedef logic [POS_W-1:0] pos_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      SETTLE,
      WAIT_REL
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

endpackage

// File: rtl/move_controller_if.sv
// Key inputs and move bus between the move controller and its neighbours.
// The controller uses the master view; the key/datapath side uses the slave view.
interface move_controller_if;
   import slide_pkg::*;

   logic             key_up;
   logic             key_down;
   logic             key_left;
   logic             key_right;
   logic             if_win;

   pos_t             move_from;
   pos_t             move_to;
   logic             move_valid;
   logic             illegal_move;
   pos_t             blank_pos;
   logic             busy;
   logic [CNT_W-1:0] move_count;

   modport master (
      input  key_up, key_down, key_left, key_right, if_win,
      output move_from, move_to, move_valid, illegal_move, blank_pos, busy, move_count
   );

   modport slave (
      output key_up, key_down, key_left, key_right, if_win,
      input  move_from, move_to, move_valid, illegal_move, blank_pos, busy, move_count
   );

endinterface

// File: rtl/move_controller_legality.sv
// Combinational move check: for a blank position and slide direction, gives the
// source block that would slide into the blank and whether it lies on the board.
module move_legality
   import slide_pkg::*;
#(
   parameter int NUM_COLS = 4
)
(
   input  pos_t i_blank_pos,
   input  dir_t i_dir,
   output pos_t o_src,
   output logic o_legal
);

   localparam int NUM_ROWS = NUM_BLOCKS / NUM_COLS;

   pos_t w_idx;
   pos_t w_row;
   pos_t w_col;
   logic w_on_board;
   logic w_dir_ok;

   // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_idx      = i_blank_pos - POS_W'(1);
      w_row      = w_idx / POS_W'(NUM_COLS);
      w_col      = w_idx % POS_W'(NUM_COLS);
      w_on_board = (i_blank_pos != '0) && (i_blank_pos <= POS_W'(NUM_BLOCKS));
      o_src      = i_blank_pos;
      w_dir_ok   = 1'b0;
      case (i_dir)
         DIR_UP: begin
            o_src    = i_blank_pos + POS_W'(NUM_COLS);
            w_dir_ok = (w_row < POS_W'(NUM_ROWS - 1));
         end
         DIR_DOWN: begin
            o_src    = i_blank_pos - POS_W'(NUM_COLS);
            w_dir_ok = (w_row != '0);
         end
         DIR_LEFT: begin
            o_src    = i_blank_pos + POS_W'(1);
            w_dir_ok = (w_col < POS_W'(NUM_COLS - 1));
         end
         DIR_RIGHT: begin
            o_src    = i_blank_pos - POS_W'(1);
            w_dir_ok = (w_col != '0);
         end
      endcase
      o_legal = w_dir_ok & w_on_board;
   end

endmodule

// File: rtl/move_controller.sv
// Turns one-hot direction keys into registered (move_from, move_to) pairs for the
// board datapath and tracks the blank. Optional move counter: define MOVE_COUNT_EN.
module move_controller
   import slide_pkg::*;
#(
   parameter int NUM_COLS = 4
)
(
   input  logic              clk,
   input  logic              resetn,
   input  pos_t              i_init_blank_pos,
   move_controller_if.master bus
);

   state_t     r_state;
   state_t     w_state_nxt;
   pos_t       r_blank_pos;
   pos_t       w_blank_nxt;
   pos_t       r_move_from;
   pos_t       w_from_nxt;
   pos_t       r_move_to;
   pos_t       w_to_nxt;
   logic       r_move_valid;
   logic       w_valid_nxt;
   logic       r_illegal_move;
   logic       w_illegal_nxt;

   logic [3:0] w_keys;
   logic       w_one_key;
   dir_t       w_dir;
   pos_t       w_src;
   logic       w_legal;

   assign w_keys    = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
   assign w_one_key = $onehot(w_keys);
   assign w_dir     = bus.key_down  ? DIR_DOWN  :
                      bus.key_left  ? DIR_LEFT  :
                      bus.key_right ? DIR_RIGHT : DIR_UP;

   move_legality #(
      .NUM_COLS (NUM_COLS)
   ) u_legality (
      .i_blank_pos (r_blank_pos),
      .i_dir       (w_dir),
      .o_src       (w_src),
      .o_legal     (w_legal)
   );

   // Outside ISSUE both pair registers sit on the blank, so the datapath swaps it with itself.
   always_comb begin
      w_state_nxt   = r_state;
      w_blank_nxt   = r_blank_pos;
      w_from_nxt    = r_blank_pos;
      w_to_nxt      = r_blank_pos;
      w_valid_nxt   = 1'b0;
      w_illegal_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_one_key && !bus.if_win) begin
               if (w_legal) begin
                  w_state_nxt = ISSUE;
                  w_from_nxt  = w_src;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt   = WAIT_REL;
                  w_illegal_nxt = 1'b1;
               end
            end
         end
         ISSUE: begin
            w_state_nxt = SETTLE;
            w_blank_nxt = r_move_from;
            w_from_nxt  = r_move_from;
            w_to_nxt    = r_move_from;
         end
         SETTLE: begin
            w_state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            if (w_keys == 4'b0000) w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state        <= WAIT_REL;
         r_blank_pos    <= i_init_blank_pos;
         r_move_from    <= i_init_blank_pos;
         r_move_to      <= i_init_blank_pos;
         r_move_valid   <= 1'b0;
         r_illegal_move <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_blank_pos    <= w_blank_nxt;
         r_move_from    <= w_from_nxt;
         r_move_to      <= w_to_nxt;
         r_move_valid   <= w_valid_nxt;
         r_illegal_move <= w_illegal_nxt;
      end
   end

`ifdef MOVE_COUNT_EN
   logic [CNT_W-1:0] r_move_count;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_move_count <= '0;
      end else if (r_move_valid && (r_move_count != CNT_MAX)) begin
         r_move_count <= r_move_count + CNT_W'(1);
      end
   end

   assign bus.move_count = r_move_count;
`else
   assign bus.move_count = '0;
`endif

   assign bus.move_from    = r_move_from;
   assign bus.move_to      = r_move_to;
   assign bus.move_valid   = r_move_valid;
   assign bus.illegal_move = r_illegal_move;
   assign bus.blank_pos    = r_blank_pos;
   assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_move_controller.sv
// Self-checking bench for move_controller: directed table, multi-cycle corner
// sequences and random key presses against a row/column board model.
module tb_move_controller;

   localparam int CNT_MAX = 999;
`ifdef MOVE_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   localparam logic [3:0] K_UP    = 4'b1000;
   localparam logic [3:0] K_DOWN  = 4'b0100;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_RIGHT = 4'b0001;

   typedef struct {
      logic [3:0] keys;
      logic       win;
      int         exp_valid;
      int         exp_illegal;
      int         exp_from;
      int         exp_to;
      int         exp_blank;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [4:0] init_blank_pos = 5'd16;

   int checks = 0;
   int failures = 0;
   int exp_blank = 16;
   int exp_cnt = 0;

   move_controller_if bus ();

   move_controller #(
      .NUM_COLS (4)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .i_init_blank_pos (init_blank_pos),
      .bus              (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_keys(input logic [3:0] m);
      bus.key_up    = m[3];
      bus.key_down  = m[2];
      bus.key_left  = m[1];
      bus.key_right = m[0];
   endtask

   function automatic int cnt_after(input int c, input int add);
      int r = c + add;
      return (r > CNT_MAX) ? CNT_MAX : r;
   endfunction

   // Board model: ev 0 = nothing, 1 = legal move from src, 2 = illegal.
   task automatic model_move(input int b, input logic [3:0] m, input logic w,
                             output int ev, output int src);
      int  r = (b - 1) / 4;
      int  c = (b - 1) % 4;
      bit  ok = 1'b0;
      ev  = 0;
      src = b;
      if (w || $countones(m) != 1) return;
      case (m)
         K_UP:    begin ok = (r < 3); src = b + 4; end
         K_DOWN:  begin ok = (r > 0); src = b - 4; end
         K_LEFT:  begin ok = (c < 3); src = b + 1; end
         default: begin ok = (c > 0); src = b - 1; end
      endcase
      ev = ok ? 1 : 2;
   endtask

   task automatic do_reset(input int b);
      @(negedge clk);
      resetn = 1'b0;
      init_blank_pos = 5'(b);
      set_keys(4'b0000);
      bus.if_win = 1'b0;
      @(negedge clk);
      check("rst_blank", bus.blank_pos, b);
      check("rst_from", bus.move_from, b);
      check("rst_to", bus.move_to, b);
      check("rst_valid", bus.move_valid, 0);
      check("rst_illegal", bus.illegal_move, 0);
      check("rst_count", bus.move_count, 0);
      check("rst_busy", bus.busy, 1);
      resetn = 1'b1;
      exp_blank = b;
      exp_cnt = 0;
      @(negedge clk);
   endtask

   // Press m for hold cycles, release, then let the FSM return to IDLE.
   task automatic press(input logic [3:0] m, input logic w, input int hold,
                        output int n_valid, output int n_illegal,
                        output int from_s, output int to_s, output int n_busy);
      n_valid = 0; n_illegal = 0; from_s = 0; to_s = 0; n_busy = 0;
      @(negedge clk);
      bus.if_win = w;
      set_keys(m);
      for (int i = 0; i < hold + 3; i++) begin
         @(negedge clk);
         if (bus.move_valid === 1'b1) begin
            n_valid++;
            from_s = bus.move_from;
            to_s = bus.move_to;
         end else begin
            check("idle_rule", (bus.move_from == bus.blank_pos) && (bus.move_to == bus.blank_pos), 1);
         end
         if (bus.illegal_move === 1'b1) n_illegal++;
         if (bus.busy === 1'b1) n_busy++;
         if (i == hold - 1) set_keys(4'b0000);
      end
      bus.if_win = 1'b0;
   endtask

   task automatic apply_and_check(input logic [3:0] m, input logic w, input int hold);
      int ev, src, nv, ni, f, t, nb;
      model_move(exp_blank, m, w, ev, src);
      press(m, w, hold, nv, ni, f, t, nb);
      check("rnd_valid", nv, (ev == 1) ? 1 : 0);
      check("rnd_illegal", ni, (ev == 2) ? 1 : 0);
      if (ev == 1) begin
         check("rnd_from", f, src);
         check("rnd_to", t, exp_blank);
         exp_blank = src;
         exp_cnt = cnt_after(exp_cnt, 1);
      end
      if (ev == 0) check("rnd_busy_idle", nb, 0);
      check("rnd_blank", bus.blank_pos, exp_blank);
      check("rnd_count", bus.move_count, COUNT_EN ? exp_cnt : 0);
   endtask

   vec_t vecs[17];

   initial begin
      int nv, ni, f, t, nb;
      logic [3:0] m;

      set_keys(4'b0000);
      bus.if_win = 1'b0;

      vecs[0]  = '{K_DOWN,          1'b0, 1, 0, 12, 16, 12};
      vecs[1]  = '{K_UP,            1'b0, 1, 0, 16, 12, 16};
      vecs[2]  = '{K_UP,            1'b0, 0, 1,  0,  0, 16};
      vecs[3]  = '{K_LEFT,          1'b0, 0, 1,  0,  0, 16};
      vecs[4]  = '{K_RIGHT,         1'b0, 1, 0, 15, 16, 15};
      vecs[5]  = '{K_UP | K_LEFT,   1'b0, 0, 0,  0,  0, 15};
      vecs[6]  = '{K_DOWN,          1'b1, 0, 0,  0,  0, 15};
      vecs[7]  = '{4'b0000,         1'b0, 0, 0,  0,  0, 15};
      vecs[8]  = '{K_DOWN,          1'b0, 1, 0, 11, 15, 11};
      vecs[9]  = '{K_RIGHT,         1'b0, 1, 0, 10, 11, 10};
      vecs[10] = '{K_LEFT,          1'b0, 1, 0, 11, 10, 11};
      vecs[11] = '{K_DOWN,          1'b0, 1, 0,  7, 11,  7};
      vecs[12] = '{K_DOWN,          1'b0, 1, 0,  3,  7,  3};
      vecs[13] = '{K_DOWN,          1'b0, 0, 1,  0,  0,  3};
      vecs[14] = '{K_RIGHT,         1'b0, 1, 0,  2,  3,  2};
      vecs[15] = '{K_RIGHT,         1'b0, 1, 0,  1,  2,  1};
      vecs[16] = '{K_RIGHT,         1'b0, 0, 1,  0,  0,  1};

      // Latency: key seen -> strobe next cycle -> new blank the cycle after.
      do_reset(16);
      @(negedge clk);
      set_keys(K_DOWN);
      @(negedge clk);
      check("lat_valid", bus.move_valid, 1);
      check("lat_from", bus.move_from, 12);
      check("lat_to", bus.move_to, 16);
      check("lat_blank_old", bus.blank_pos, 16);
      check("lat_busy", bus.busy, 1);
      @(negedge clk);
      check("lat_valid_drop", bus.move_valid, 0);
      check("lat_blank_new", bus.blank_pos, 12);
      check("lat_settle_pair", {bus.move_from, bus.move_to}, {5'd12, 5'd12});
      set_keys(4'b0000);
      repeat (3) @(negedge clk);

      // Illegal pulse is a single cycle and leaves the blank alone.
      do_reset(16);
      @(negedge clk);
      set_keys(K_UP);
      @(negedge clk);
      check("ill_pulse", bus.illegal_move, 1);
      check("ill_no_valid", bus.move_valid, 0);
      @(negedge clk);
      check("ill_pulse_end", bus.illegal_move, 0);
      check("ill_blank", bus.blank_pos, 16);
      set_keys(4'b0000);
      repeat (3) @(negedge clk);

      // Directed table from a fresh board with the blank at 16.
      do_reset(16);
      foreach (vecs[i]) begin
         press(vecs[i].keys, vecs[i].win, 4, nv, ni, f, t, nb);
         check($sformatf("vec%0d_valid", i), nv, vecs[i].exp_valid);
         check($sformatf("vec%0d_illegal", i), ni, vecs[i].exp_illegal);
         if (vecs[i].exp_valid == 1) begin
            check($sformatf("vec%0d_from", i), f, vecs[i].exp_from);
            check($sformatf("vec%0d_to", i), t, vecs[i].exp_to);
            exp_cnt = cnt_after(exp_cnt, 1);
         end
         if (vecs[i].exp_valid == 0 && vecs[i].exp_illegal == 0)
            check($sformatf("vec%0d_busy", i), nb, 0);
         check($sformatf("vec%0d_blank", i), bus.blank_pos, vecs[i].exp_blank);
         check($sformatf("vec%0d_count", i), bus.move_count, COUNT_EN ? exp_cnt : 0);
      end

      // A held key moves once; the next move needs a release and re-press.
      do_reset(6);
      press(K_LEFT, 1'b0, 20, nv, ni, f, t, nb);
      check("hold_one_move", nv, 1);
      check("hold_from", f, 7);
      check("hold_to", t, 6);
      check("hold_blank", bus.blank_pos, 7);
      press(K_LEFT, 1'b0, 4, nv, ni, f, t, nb);
      check("repress_move", nv, 1);
      check("repress_from", f, 8);
      check("repress_blank", bus.blank_pos, 8);

      // Reset asserted while the move strobe is out; held key must stay ignored.
      do_reset(16);
      @(negedge clk);
      set_keys(K_DOWN);
      @(negedge clk);
      check("mid_issue_seen", bus.move_valid, 1);
      resetn = 1'b0;
      init_blank_pos = 5'd1;
      @(negedge clk);
      check("mid_rst_blank", bus.blank_pos, 1);
      check("mid_rst_from", bus.move_from, 1);
      check("mid_rst_to", bus.move_to, 1);
      check("mid_rst_count", bus.move_count, 0);
      check("mid_rst_valid", bus.move_valid, 0);
      resetn = 1'b1;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.move_valid === 1'b1) nv++;
      end
      check("mid_rst_held_key", nv, 0);
      check("mid_rst_blank_hold", bus.blank_pos, 1);
      set_keys(4'b0000);
      repeat (2) @(negedge clk);

      // Random presses against the board model.
      do_reset(int'($urandom_range(1, 16)));
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 6) m = 4'(1 << $urandom_range(0, 3));
         else m = 4'($urandom_range(0, 15));
         apply_and_check(m, ($urandom_range(0, 7) == 0), int'($urandom_range(2, 5)));
      end

`ifdef MOVE_COUNT_EN
      // Counter saturation over 1001 legal moves.
      do_reset(16);
      for (int i = 0; i < 1001; i++) begin
         apply_and_check((i % 2 == 0) ? K_DOWN : K_UP, 1'b0, 2);
      end
      check("sat_count", bus.move_count, exp_cnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
